// File: rtl/des_pkg.sv
// Shared DES constants, permutation helpers and types for the encrypt and decrypt tops.
// Bit 63 of every 64-bit vector is DES bit 1.
package des_pkg;

  typedef logic [27:0] half_key_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_OUT} state_t;

  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Encryption left-shift amounts for subkeys K1..K16.
  localparam int SHIFT_SCHED [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Row-major S-box contents; entry index is {b5, b0, b4..b1}.
  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TBL[6'(i)])];
    return y;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TBL[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] des_e(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_TBL[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] des_p(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_TBL[5'(i)])];
    return y;
  endfunction

  function automatic logic [55:0] des_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_TBL[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] des_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_TBL[6'(i)])];
    return y;
  endfunction

  function automatic logic [3:0] des_sbox(input logic [2:0] n, input logic [5:0] b);
    return 4'(SBOX[n][{b[5], b[0], b[4:1]}]);
  endfunction

  // Decryption round k undoes the shift that produced K(17-k).
  function automatic logic dec_rot_one(input logic [4:0] k);
    return SHIFT_SCHED[4'(16 - k)] == 1;
  endfunction

  function automatic half_key_t des_ror(input half_key_t x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

endpackage

// File: rtl/des_round_f.sv
// DES round function f(R, K) = P(S(E(R) ^ K)); purely combinational, shared by both directions.
module des_round_f
  import des_pkg::*;
(
  input  logic [31:0] i_r,
  input  logic [47:0] i_k,
  output logic [31:0] o_f
);

  logic [47:0] w_x;
  logic [31:0] w_s;

  assign w_x = des_e(i_r) ^ i_k;

  for (genvar g = 0; g < 8; g++) begin : g_sbox
    assign w_s[31 - 4*g -: 4] = des_sbox(3'(g), w_x[47 - 6*g -: 6]);
  end

  assign o_f = des_p(w_s);

endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption: one Feistel round per clock, subkeys generated by right-rotating
// C/D so K16 comes straight out of PC-1 and the schedule runs backwards.
module des_decrypt_core
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] key_in,
  input  logic [63:0] data_in,
  input  logic        load,
  output logic [63:0] data_out,
  output logic        valid,
  output logic        busy
);

  state_t      r_state;
  logic [4:0]  r_rnd;
  logic [31:0] r_l, r_r;
  half_key_t   r_c, r_d;
  logic [63:0] r_data_out;
  logic        r_valid, r_busy;

  logic [63:0] w_ip;
  logic [55:0] w_pc1;
  logic [47:0] w_subkey;
  logic [31:0] w_f;
  logic        w_rot_one;

  assign w_ip      = des_ip(data_in);
  assign w_pc1     = des_pc1(key_in);
  assign w_subkey  = des_pc2({r_c, r_d});
  assign w_rot_one = dec_rot_one(r_rnd);

  des_round_f u_round_f (
    .i_r (r_r),
    .i_k (w_subkey),
    .o_f (w_f)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_rnd      <= 5'd0;
      r_l        <= 32'h0;
      r_r        <= 32'h0;
      r_c        <= '0;
      r_d        <= '0;
      r_data_out <= 64'h0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_l     <= w_ip[63:32];
            r_r     <= w_ip[31:0];
            r_c     <= w_pc1[55:28];
            r_d     <= w_pc1[27:0];
            r_rnd   <= 5'd1;
            r_busy  <= 1'b1;
            r_state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_l <= r_r;
          r_r <= r_l ^ w_f;
          r_c <= des_ror(r_c, w_rot_one);
          r_d <= des_ror(r_d, w_rot_one);
          if (r_rnd == 5'd16) begin
            r_state <= ST_OUT;
          end else begin
            r_rnd <= r_rnd + 5'd1;
          end
        end
        ST_OUT: begin
          // Halves are swapped back before the final permutation.
          r_data_out <= des_fp({r_r, r_l});
          r_valid    <= 1'b1;
          r_busy     <= 1'b0;
          r_rnd      <= 5'd0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign data_out = r_data_out;
  assign valid    = r_valid;
  assign busy     = r_busy;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed bench for des_decrypt_core: known-answer vectors, busy/load protocol, input hold, reset abort.
module tb_des_decrypt_core;

  localparam logic [63:0] K_CL  = 64'h133457799BBCDFF1;
  localparam logic [63:0] CT_CL = 64'h85E813540F0AB405;
  localparam logic [63:0] PT_CL = 64'h0123456789ABCDEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] key_in, data_in;
  logic        load;
  logic [63:0] data_out;
  logic        valid, busy;

  int checks   = 0;
  int failures = 0;

  int          lat, nv;
  logic [63:0] dout;
  bit          busy_ok, pos_ok;

  des_decrypt_core dut (
    .clk      (clk),
    .reset    (reset),
    .key_in   (key_in),
    .data_in  (data_in),
    .load     (load),
    .data_out (data_out),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge. Load is presented for E0, optionally re-pulsed at
  // cycles ra/rb with different data, optionally with inputs scrambled after acceptance.
  task automatic do_block(input logic [63:0] k, input logic [63:0] d, input int ra, input int rb,
                          input bit scramble, output int o_lat, output int o_nv,
                          output logic [63:0] o_dout, output bit o_busy_ok);
    o_lat = -1; o_nv = 0; o_dout = 'x; o_busy_ok = 1;
    for (int i = 0; i <= 24; i++) begin
      load = (i == 0) || (i == ra) || (i == rb);
      if (i == 0) begin
        key_in = k; data_in = d;
      end else if (scramble) begin
        key_in = {$urandom, $urandom}; data_in = {$urandom, $urandom};
      end else if (load) begin
        data_in = 64'hDEAD_BEEF_0000_0000 ^ 64'(i);
      end
      @(negedge clk);
      if (valid) begin
        o_nv++;
        if (o_nv == 1) begin o_lat = i; o_dout = data_out; end
      end
      if (i <= 16 && busy !== 1'b1) o_busy_ok = 0;
      if (i == 17 && busy !== 1'b0) o_busy_ok = 0;
    end
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; load = 1'b0; key_in = '0; data_in = '0;
    repeat (2) @(negedge clk);
    check("rst_data_out", data_out, 64'h0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Classic vector with latency and busy window
    do_block(K_CL, CT_CL, -1, -1, 0, lat, nv, dout, busy_ok);
    check("classic_latency", 64'(lat), 64'd17);
    check("classic_nvalid", 64'(nv), 64'd1);
    check("classic_data", dout, PT_CL);
    check("classic_busy", 64'(busy_ok), 64'd1);
    check("classic_hold", data_out, PT_CL);

    do_block(64'h8001010101010101, 64'h95A8D72813DAA94D, -1, -1, 0, lat, nv, dout, busy_ok);
    check("varkey_data", dout, 64'h0);
    do_block(64'h8000000000000000, 64'h95A8D72813DAA94D, -1, -1, 0, lat, nv, dout, busy_ok);
    check("varkey_parity_data", dout, 64'h0);
    check("varkey_parity_latency", 64'(lat), 64'd17);

    do_block(64'h0101010101010101, 64'h8CA64DE9C1B123A7, -1, -1, 0, lat, nv, dout, busy_ok);
    check("weak_data", dout, 64'h0);

    // Loads while busy / in OUT are dropped
    do_block(K_CL, CT_CL, 5, 17, 0, lat, nv, dout, busy_ok);
    check("ignore_nvalid", 64'(nv), 64'd1);
    check("ignore_data", dout, PT_CL);
    check("ignore_latency", 64'(lat), 64'd17);
    check("ignore_busy", 64'(busy_ok), 64'd1);

    // Continuous load: one block every 18 cycles
    key_in = K_CL; data_in = CT_CL;
    nv = 0; pos_ok = 1;
    for (int i = 0; i <= 54; i++) begin
      load = (i < 54);
      @(negedge clk);
      if (valid) begin
        nv++;
        if (!(i == 17 || i == 35 || i == 53)) pos_ok = 0;
      end
    end
    load = 1'b0;
    check("stream_nvalid", 64'(nv), 64'd3);
    check("stream_positions", 64'(pos_ok), 64'd1);
    check("stream_data", data_out, PT_CL);
    repeat (20) @(negedge clk);

    // Inputs scrambled after acceptance
    do_block(K_CL, CT_CL, -1, -1, 1, lat, nv, dout, busy_ok);
    check("scramble_data", dout, PT_CL);
    check("scramble_latency", 64'(lat), 64'd17);

    // Reset abort at round 8
    check("pre_abort_data", data_out, PT_CL);
    key_in = K_CL; data_in = CT_CL; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_data_out", data_out, 64'h0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(valid), 64'd0);
    nv = 0;
    repeat (3) begin
      @(negedge clk);
      if (valid) nv++;
    end
    check("abort_no_valid", 64'(nv), 64'd0);
    reset = 1'b1;
    do_block(K_CL, CT_CL, -1, -1, 0, lat, nv, dout, busy_ok);
    check("after_abort_data", dout, PT_CL);
    check("after_abort_latency", 64'(lat), 64'd17);
    check("after_abort_nvalid", 64'(nv), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
